// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter:
// FSM state encoding, common keyboard command bytes, bit-position
// markers within a frame, and the odd-parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERROR
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // Device clock falling-edge numbers within one frame
  localparam logic [3:0] EDGE_LAST_DATA = 4'd8;
  localparam logic [3:0] EDGE_PARITY    = 4'd9;
  localparam logic [3:0] EDGE_STOP      = 4'd10;
  localparam logic [3:0] EDGE_ACK       = 4'd11;

  // Extra attempts allowed when retry support is built in
  localparam logic [1:0] MAX_RETRIES = 2'd2;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 line. Two-flop synchronizer,
// then a level filter that accepts a new level only after FILTER_LEN
// consecutive identical samples, plus a one-cycle strobe on a filtered
// 1->0 transition. Idle (released) lines read high, so everything
// resets to 1.
module ps2_line_filter
  import ps2_host_tx_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_async,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; flip on the last one
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = level_q & ~level_d;
  end

  // Synchronizer, filter state and edge strobe registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_async;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, issues request-to-send, then shifts out start, 8 data
// bits LSB first, odd parity and stop on device clock falling edges, and
// samples the device ACK on the 11th edge. Lines are driven open-drain via
// pull-low enables. Optional macro PS2_TX_RETRY_EN re-sends a NACKed or
// timed-out frame up to two more times before reporting the error.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  // The cycle-count parameters assume a clock of at least 1 MHz
  if (CLK_HZ < 1000000) begin : g_clk_check
    $error("ps2_host_tx: CLK_HZ too low for PS/2 timing");
  end

  logic clk_lvl, clk_fall, dat_lvl;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_async (ps2_clk_async),
    .level      (clk_lvl),
    .fall       (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_async (ps2_data_async),
    .level      (dat_lvl),
    .fall       ()
  );

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       edge_q, edge_d, edge_nx;
  logic [7:0]       byte_q, byte_d;
  logic             par_q, par_d;
  logic             nack_q, nack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             retry_ok;

`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
  assign retry_ok = (retry_q != MAX_RETRIES);
`else
  assign retry_ok = 1'b0;
`endif

  // Next-state and next-output logic for the transmit sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    edge_d    = edge_q;
    byte_d    = byte_q;
    par_d     = par_q;
    nack_d    = nack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = error_q;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    edge_nx   = edge_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          byte_d   = tx_data;
          par_d    = odd_parity(tx_data);
          error_d  = 1'b0;
          nack_d   = 1'b0;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d  = 2'd0;
`endif
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = ST_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RTS: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          edge_d   = '0;
          to_d     = '0;
          state_d  = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        // A falling edge takes priority over a coincident timeout
        if (clk_fall) begin
          to_d   = '0;
          edge_d = edge_nx;
          if (edge_nx <= EDGE_LAST_DATA) begin
            data_oe_d = ~byte_q[edge_q[2:0]];
          end else if (edge_nx == EDGE_PARITY) begin
            data_oe_d = ~par_q;
          end else if (edge_nx == EDGE_STOP) begin
            data_oe_d = 1'b0;
          end else begin
            nack_d    = dat_lvl;
            data_oe_d = 1'b0;
            state_d   = ST_WAIT_IDLE;
          end
        end else if (to_q == TO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = ST_ERROR;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_lvl && dat_lvl) begin
          state_d = ST_DONE;
        end else if (clk_fall) begin
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = ST_ERROR;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (nack_q && retry_ok) begin
`ifdef PS2_TX_RETRY_EN
          retry_d = retry_q + 2'd1;
`endif
          cnt_d     = '0;
          nack_d    = 1'b0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = ST_INHIBIT;
        end else begin
          done_d  = 1'b1;
          error_d = nack_q;
          state_d = ST_IDLE;
        end
      end

      ST_ERROR: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (clk_lvl && dat_lvl) begin
          if (retry_ok) begin
`ifdef PS2_TX_RETRY_EN
            retry_d = retry_q + 2'd1;
`endif
            cnt_d    = '0;
            nack_d   = 1'b0;
            clk_oe_d = 1'b1;
            state_d  = ST_INHIBIT;
          end else begin
            done_d  = 1'b1;
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) && clk_lvl && dat_lvl;
    busy_d  = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs; reset releases both lines at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      edge_q    <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      edge_q    <= edge_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      nack_q    <= nack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = ready_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the
// open-drain lines. The timeout is shortened to keep the run short.
module tb_ps2_host_tx;

  localparam int TIMEOUT = 2000;
  localparam int HALF    = 40;

`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_error, busy;
  logic       clk_pin, data_pin;

  assign clk_pin  = dev_clk & ~ps2_clk_oe;
  assign data_pin = dev_dat & ~ps2_data_oe;

  ps2_host_tx #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ps2_clk_async  (clk_pin),
    .ps2_data_async (data_pin),
    .ps2_clk_oe     (ps2_clk_oe),
    .ps2_data_oe    (ps2_data_oe),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_done        (tx_done),
    .tx_error       (tx_error),
    .busy           (busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus monitor
  int         frames = 0, done_cnt = 0, inh_run = 0, rts_run = 0;
  logic       clk_oe_prev = 1'b0;
  logic       last_err = 1'b0, busy_at_done = 1'b0, ready_at_done = 1'b0;
  logic [1:0] oe_at_done = 2'b00;
  logic [10:0] dev_bits;
  logic       dev_start;

  always @(negedge clk) begin
    if (ps2_clk_oe && !clk_oe_prev) begin
      frames  = frames + 1;
      inh_run = 0;
      rts_run = 0;
    end
    if (ps2_clk_oe && !ps2_data_oe) inh_run = inh_run + 1;
    if (ps2_clk_oe && ps2_data_oe) rts_run = rts_run + 1;
    clk_oe_prev = ps2_clk_oe;
    if (tx_done) begin
      done_cnt      = done_cnt + 1;
      last_err      = tx_error;
      busy_at_done  = busy;
      ready_at_done = tx_ready;
      oe_at_done    = {ps2_clk_oe, ps2_data_oe};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int g;
    g = 0;
    while (!tx_ready && g < 1000) begin @(negedge clk); g++; end
    check("send_ready", 32'(g < 1000), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device: wait for request-to-send, then clock nedges falling edges,
  // sampling host data just before each rising edge.
  task automatic device_frame(input int nedges, input bit nack);
    int g;
    g = 0;
    while (!(ps2_clk_oe && ps2_data_oe) && g < 30000) begin @(negedge clk); g++; end
    while (ps2_clk_oe && g < 30000) begin @(negedge clk); g++; end
    check("dev_rts_wait", 32'(g < 30000), 32'd1);
    dev_start = data_pin;
    repeat (30) @(negedge clk);
    for (int n = 1; n <= nedges; n++) begin
      if (n == 11) begin
        dev_dat = nack;
        repeat (20) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_bits[n-1] = data_pin;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_done(input int prev, input int limit);
    int g;
    g = 0;
    while (done_cnt == prev && g < limit) begin @(negedge clk); g++; end
    check("done_seen", 32'(g < limit), 32'd1);
  endtask

  int prev_done, prev_frames, g;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_error", 32'(tx_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    // 0xED with ACK
    prev_done = done_cnt;
    send(8'hED);
    check("busy_after_accept", 32'(busy), 32'd1);
    device_frame(11, 1'b0);
    check("inhibit_len", 32'(inh_run), 32'd5000);
    check("rts_len", 32'(rts_run), 32'd50);
    check("ed_start", 32'(dev_start), 32'd0);
    check("ed_bits", 32'(dev_bits[7:0]), 32'h0000_00ED);
    check("ed_parity", 32'(dev_bits[8]), 32'd1);
    check("ed_stop", 32'(dev_bits[9]), 32'd1);
    wait_done(prev_done, 200);
    check("ed_done_count", 32'(done_cnt - prev_done), 32'd1);
    check("ed_error", 32'(last_err), 32'd0);
    check("ed_busy_at_done", 32'(busy_at_done), 32'd0);

    // 0xF4 with ACK: parity 0
    prev_done = done_cnt;
    send(8'hF4);
    device_frame(11, 1'b0);
    check("f4_bits", 32'(dev_bits[7:0]), 32'h0000_00F4);
    check("f4_parity", 32'(dev_bits[8]), 32'd0);
    wait_done(prev_done, 200);
    check("f4_error", 32'(last_err), 32'd0);

    // 0xFF with NACK on every attempt
    repeat (20) @(negedge clk);
    prev_done   = done_cnt;
    prev_frames = frames;
    send(8'hFF);
    for (int a = 0; a < ATTEMPTS; a++) begin
      device_frame(11, 1'b1);
      check("ff_parity", 32'(dev_bits[8]), 32'd1);
    end
    wait_done(prev_done, 200);
    check("nack_error", 32'(last_err), 32'd1);
    check("nack_frames", 32'(frames - prev_frames), 32'(ATTEMPTS));
    check("nack_done_count", 32'(done_cnt - prev_done), 32'd1);
    repeat (100) @(negedge clk);
    check("error_hold", 32'(tx_error), 32'd1);

    // Device stalls after edge 4 (0xF4 bit3 = 0 keeps data pulled)
    prev_done = done_cnt;
    send(8'hF4);
    check("error_cleared", 32'(tx_error), 32'd0);
    device_frame(4, 1'b0);
    repeat (1700) @(negedge clk);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_data_oe", 32'(ps2_data_oe), 32'd1);
    check("stall_no_done", 32'(done_cnt - prev_done), 32'd0);
    wait_done(prev_done, 1000 + (ATTEMPTS - 1) * 8000);
    check("timeout_error", 32'(last_err), 32'd1);
    check("timeout_oe", 32'(oe_at_done), 32'd0);
    check("timeout_busy", 32'(busy_at_done), 32'd0);

    // Reset during SHIFT after edge 6 (0x5A bit5 = 0 keeps data pulled)
    prev_done = done_cnt;
    send(8'h5A);
    device_frame(6, 1'b0);
    check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_no_done", 32'(done_cnt - prev_done), 32'd0);

    // tx_valid held through the frame with a different byte
    prev_frames = frames;
    g = 0;
    while (!tx_ready && g < 1000) begin @(negedge clk); g++; end
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data  = 8'hF4;
    device_frame(11, 1'b0);
    g = 0;
    while (!tx_done && g < 200) begin @(negedge clk); g++; end
    tx_valid = 1'b0;
    check("hold_done_seen", 32'(g < 200), 32'd1);
    check("hold_ready_at_done", 32'(tx_ready), 32'd1);
    check("hold_bits", 32'(dev_bits[7:0]), 32'h0000_00ED);
    repeat (300) @(negedge clk);
    check("hold_frames", 32'(frames - prev_frames), 32'd1);
    check("hold_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
